// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci/Galois LFSR pseudo-random generator with multi-step advance,
// runtime seed load, all-zero lock-up protection and a period-wrap marker.
module lfsr_prng #(
  parameter int unsigned                NUM_BITS = 5,
  parameter logic [NUM_BITS-1:0]        TAPS     = 5'h14,
  parameter logic [NUM_BITS-1:0]        SEED     = 5'd1,
  parameter bit                         MODE     = 1'b0,
  parameter int unsigned                STEPS    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_value,
  output logic [NUM_BITS-1:0] state,
  output logic [STEPS-1:0]    rand_bits,
  output logic                bits_valid,
  output logic                wrap,
  output logic                lockup
);

  if (NUM_BITS < 2 || NUM_BITS > 32) begin : g_bad_width
    $error("lfsr_prng: NUM_BITS must be within 2..32");
  end
  if (TAPS[NUM_BITS-1] == 1'b0) begin : g_bad_taps
    $error("lfsr_prng: TAPS must have bit NUM_BITS-1 set");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: SEED must be nonzero");
  end
  if (STEPS < 1 || STEPS > NUM_BITS) begin : g_bad_steps
    $error("lfsr_prng: STEPS must be within 1..NUM_BITS");
  end

  logic [NUM_BITS-1:0] state_q, state_d;
  logic [STEPS-1:0]    bits_q, bits_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic                lockup_q, lockup_d;

  logic [NUM_BITS-1:0] walk;
  logic [STEPS-1:0]    adv_bits;

  // STEPS single steps unrolled into one combinational chain; bit i is the output of step i.
  always_comb begin
    walk     = state_q;
    adv_bits = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (MODE == 1'b0) begin
        adv_bits[i] = walk[NUM_BITS-1];
        walk        = {walk[NUM_BITS-2:0], ^(walk & TAPS)};
      end else begin
        adv_bits[i] = walk[0];
        walk        = (walk >> 1) ^ ({NUM_BITS{walk[0]}} & TAPS);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      if (load_value == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d  = load_value;
      end
    end else if (en) begin
      state_d = walk;
      bits_d  = adv_bits;
      valid_d = 1'b1;
      wrap_d  = (walk == SEED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEED;
      bits_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bits_q   <= bits_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign state      = state_q;
  assign rand_bits  = bits_q;
  assign bits_valid = valid_q;
  assign wrap       = wrap_q;
  assign lockup     = lockup_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: Fibonacci, Galois and 5-step instances driven in parallel.
module tb_lfsr_prng;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_value = '0;

  always #5 clk = ~clk;

  logic [4:0] fib_state, gal_state, s5_state;
  logic       fib_bits, gal_bits;
  logic [4:0] s5_bits;
  logic [2:0] d_valid, d_wrap, d_lock;

  lfsr_prng #(.NUM_BITS(5), .TAPS(5'h14), .SEED(5'd1), .MODE(1'b0), .STEPS(1)) u_fib (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_value(load_value),
    .state(fib_state), .rand_bits(fib_bits), .bits_valid(d_valid[0]),
    .wrap(d_wrap[0]), .lockup(d_lock[0]));

  lfsr_prng #(.NUM_BITS(5), .TAPS(5'h14), .SEED(5'd1), .MODE(1'b1), .STEPS(1)) u_gal (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_value(load_value),
    .state(gal_state), .rand_bits(gal_bits), .bits_valid(d_valid[1]),
    .wrap(d_wrap[1]), .lockup(d_lock[1]));

  lfsr_prng #(.NUM_BITS(5), .TAPS(5'h14), .SEED(5'd1), .MODE(1'b0), .STEPS(5)) u_s5 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_value(load_value),
    .state(s5_state), .rand_bits(s5_bits), .bits_valid(d_valid[2]),
    .wrap(d_wrap[2]), .lockup(d_lock[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_state(input int k);
    return (k == 0) ? int'(fib_state) : (k == 1) ? int'(gal_state) : int'(s5_state);
  endfunction

  function automatic int dut_bits(input int k);
    return (k == 0) ? int'(fib_bits) : (k == 1) ? int'(gal_bits) : int'(s5_bits);
  endfunction

  // Reference model: integer arithmetic on the register value, per instance k.
  int m_state[3], m_bits[3], m_valid[3], m_wrap[3], m_lock[3];
  localparam int TAPV = 'h14;

  function automatic int ref_step(input int v, input int galois, output int o);
    if (galois == 0) begin
      o = v / 16;
      return ((v * 2) % 32) + ($countones(v & TAPV) % 2);
    end
    o = v % 2;
    return (o == 1) ? ((v / 2) ^ TAPV) : (v / 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = 1; m_bits[k] = 0; m_valid[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
    end
  endtask

  task automatic model_clock(input int e, input int l, input int lv);
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
      if (l != 0) begin
        if (lv == 0) begin m_state[k] = 1; m_lock[k] = 1; end
        else m_state[k] = lv;
      end else if (e != 0) begin
        int v, b, o, n;
        v = m_state[k]; b = 0;
        n = (k == 2) ? 5 : 1;
        for (int i = 0; i < n; i++) begin
          v = ref_step(v, (k == 1) ? 1 : 0, o);
          b += o << i;
        end
        m_state[k] = v; m_bits[k] = b; m_valid[k] = 1; m_wrap[k] = (v == 1) ? 1 : 0;
      end
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_state[%0d]", k), dut_state(k), m_state[k]);
      chk($sformatf("model_bits[%0d]", k), dut_bits(k), m_bits[k]);
      chk($sformatf("model_valid[%0d]", k), int'(d_valid[k]), m_valid[k]);
      chk($sformatf("model_wrap[%0d]", k), int'(d_wrap[k]), m_wrap[k]);
      chk($sformatf("model_lockup[%0d]", k), int'(d_lock[k]), m_lock[k]);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare 1 time unit later.
  task automatic cyc(input logic e, input logic l, input logic [4:0] lv);
    en = e; load = l; load_value = lv;
    @(posedge clk);
    model_clock(int'(e), int'(l), int'(lv));
    #1;
    model_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    model_reset();
    #2;
    model_check();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       e, l;
    logic [4:0] lv;
    logic [4:0] st;
    logic       bits, valid, lock;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'h00, 5'h02, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5'h00, 5'h04, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5'h00, 5'h09, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'h00, 5'h12, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'h00, 5'h05, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'h00, 5'h05, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 5'h00, 5'h01, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 5'h0A, 5'h0A, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'h00, 5'h14, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'h00, 5'h08, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 5'h00, 5'h1F, 1'b1, 1'b0, 1'b0};
  end

  initial begin
    logic [4:0] gal_exp[5];
    logic       gal_bexp[5];
    logic [4:0] fib_exp[5];
    gal_exp  = '{5'h14, 5'h0A, 5'h05, 5'h16, 5'h0B};
    gal_bexp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    fib_exp  = '{5'h02, 5'h04, 5'h09, 5'h12, 5'h05};

    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("reset_state", dut_state(k), 1);
      chk("reset_bits", dut_bits(k), 0);
      chk("reset_pulses", int'({d_valid[k], d_wrap[k], d_lock[k]}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fibonacci sequence, hold, load with lock-up replacement, reload.
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].e, vecs[i].l, vecs[i].lv);
      chk($sformatf("vec%0d_state", i), int'(fib_state), int'(vecs[i].st));
      chk($sformatf("vec%0d_bits", i), int'(fib_bits), int'(vecs[i].bits));
      chk($sformatf("vec%0d_valid", i), int'(d_valid[0]), int'(vecs[i].valid));
      chk($sformatf("vec%0d_lockup", i), int'(d_lock[0]), int'(vecs[i].lock));
    end

    // Galois sequence and single 5-step advance from the seed.
    do_reset();
    cyc(1'b1, 1'b0, 5'h00);
    chk("s5_state", int'(s5_state), 'h05);
    chk("s5_bits", int'(s5_bits), 'b10000);
    chk("s5_valid", int'(d_valid[2]), 1);
    chk("gal_state0", int'(gal_state), int'(gal_exp[0]));
    chk("gal_bits0", int'(gal_bits), int'(gal_bexp[0]));
    cyc(1'b0, 1'b0, 5'h00);
    chk("s5_valid_drop", int'(d_valid[2]), 0);
    chk("s5_state_hold", int'(s5_state), 'h05);
    for (int i = 1; i < 5; i++) begin
      cyc(1'b1, 1'b0, 5'h00);
      chk($sformatf("gal_state%0d", i), int'(gal_state), int'(gal_exp[i]));
      chk($sformatf("gal_bits%0d", i), int'(gal_bits), int'(gal_bexp[i]));
    end

    // Full period: 31 distinct states, single wrap pulse on the 31st advance.
    do_reset();
    begin
      bit seen[2][32];
      int distinct[2], wraps[2], s;
      for (int k = 0; k < 2; k++) begin
        distinct[k] = 0; wraps[k] = 0;
        for (int j = 0; j < 32; j++) seen[k][j] = 1'b0;
      end
      for (int c = 1; c <= 31; c++) begin
        cyc(1'b1, 1'b0, 5'h00);
        for (int k = 0; k < 2; k++) begin
          s = dut_state(k);
          if (!seen[k][s]) distinct[k]++;
          seen[k][s] = 1'b1;
          if (d_wrap[k]) wraps[k]++;
          if (c == 31) chk($sformatf("wrap_at_31[%0d]", k), int'(d_wrap[k]), 1);
        end
      end
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("period_distinct[%0d]", k), distinct[k], 31);
        chk($sformatf("period_wraps[%0d]", k), wraps[k], 1);
        chk($sformatf("period_no_zero[%0d]", k), int'(seen[k][0]), 0);
      end
    end

    // Reset asserted between edges while advancing, then resume from the seed.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'h00);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk("midrst_state", dut_state(k), 1);
      chk("midrst_pulses", int'({d_valid[k], d_wrap[k], d_lock[k]}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 5'h00);
      chk($sformatf("resume%0d", i), int'(fib_state), int'(fib_exp[i]));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic       e, l;
      logic [4:0] lv;
      e  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 7) == 0);
      lv = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
      cyc(e, l, lv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
